// File: rtl/dmem_bus_if_if.sv
// Word-access req/ack data bus between the MEM-stage bus interface (master)
// and the data memory (slave).
interface dmem_bus_if_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_if.sv
// MEM-stage data-memory bus interface: stalls the pipeline while one word
// access is outstanding on the req/ack bus and returns registered load data.
module dmem_bus_if #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_addr,
  input  logic          mem_we,
  input  logic          mem_re,
  input  logic [31:0]   mem_wd,
  input  logic          pipe_hold,
  output logic [31:0]   mem_data_o,
  output logic          mem_stall,
  output logic          dmem_err,
  dmem_bus_if_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             err_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             load_q;

  logic acc;
  logic aligned;

  assign acc     = mem_we | mem_re;
  assign aligned = (mem_addr[1:0] == 2'b00);

  // The IDLE cycle of an aligned access already stalls so MEM inputs stay put.
  assign mem_stall = (state_q == BUSY) || ((state_q == IDLE) && acc && aligned);

  assign mem_data_o    = data_q;
  assign dmem_err      = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && aligned) begin
            addr_q  <= {mem_addr[31:2], 2'b00};
            wdata_q <= mem_wd;
            we_q    <= mem_we;
            load_q  <= ~mem_we;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= BUSY;
          end else if (acc) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            err_q   <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            req_q <= 1'b0;
            if (load_q) begin
              data_q <= bus.bus_err ? '0 : bus.bus_rdata;
            end
            err_q   <= bus.bus_err;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q <= 1'b0;
            if (load_q) begin
              data_q <= '0;
            end
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (!pipe_hold) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table plus randomized
// transactions checked against a transaction-level reference model.
module tb_dmem_bus_if;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wd;
  logic        pipe_hold;
  logic [31:0] mem_data_o;
  logic        mem_stall;
  logic        dmem_err;

  dmem_bus_if_if bus_if ();

  dmem_bus_if #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wd    (mem_wd),
    .pipe_hold (pipe_hold),
    .mem_data_o(mem_data_o),
    .mem_stall (mem_stall),
    .dmem_err  (dmem_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned ack_on;   // BUSY-relative cycle carrying bus_ack, 0 = never
    logic        err;
    logic [31:0] rdata;
    int unsigned hold;     // extra DONE cycles with pipe_hold=1
    logic [31:0] exp_data;
    logic        exp_err;
    int unsigned exp_stall;
    int unsigned exp_req;
  } vec_t;

  int unsigned cmp_cnt  = 0;
  int unsigned fail_cnt = 0;
  logic [31:0] model_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic re, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input int unsigned ack_on, input logic err,
                              input logic [31:0] rdata, input int unsigned hold,
                              input logic [31:0] exp_data, input logic exp_err,
                              input int unsigned exp_stall, input int unsigned exp_req);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wd = wd; v.ack_on = ack_on; v.err = err;
    v.rdata = rdata; v.hold = hold; v.exp_data = exp_data; v.exp_err = exp_err;
    v.exp_stall = exp_stall; v.exp_req = exp_req;
    return v;
  endfunction

  // Transaction-level outcome: stall/request cycle counts and final DONE values.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    vec_t        r = v;
    logic        to;
    int unsigned busy;
    r.exp_data = prev;
    r.exp_stall = 0;
    r.exp_req = 0;
    r.exp_err = 1'b0;
    if (v.re || v.we) begin
      if (v.addr[1:0] != 2'b00) begin
        r.exp_err = 1'b1;
      end else begin
        to = (v.ack_on == 0) || (v.ack_on > TMO);
        busy = to ? TMO : v.ack_on;
        r.exp_stall = busy + 1;
        r.exp_req = busy;
        r.exp_err = to | v.err;
        if (v.re && !v.we) r.exp_data = (to | v.err) ? 32'h0 : v.rdata;
      end
    end
    return r;
  endfunction

  task automatic drive_bus(input vec_t v, input int unsigned idx);
    bus_if.bus_ack   = (v.ack_on != 0) && (idx == v.ack_on);
    bus_if.bus_err   = bus_if.bus_ack ? v.err : 1'($urandom);
    bus_if.bus_rdata = bus_if.bus_ack ? v.rdata : $urandom;
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input string tag);
    int unsigned idx = 0;
    int unsigned stalls;
    int unsigned reqs = 0;
    mem_re = v.re; mem_we = v.we; mem_addr = v.addr; mem_wd = v.wd;
    pipe_hold = 1'($urandom);
    bus_if.bus_ack = 1'b0;
    #1;
    stalls = mem_stall ? 1 : 0;
    chk({tag, " req_low_in_idle"}, 32'(bus_if.bus_req), 32'h0);
    if (!(v.re || v.we)) begin
      chk({tag, " idle_stall"}, 32'(mem_stall), 32'h0);
      @(posedge clk); #1;
      chk({tag, " idle_err"}, 32'(dmem_err), 32'(v.exp_err));
      chk({tag, " idle_data"}, mem_data_o, v.exp_data);
      return;
    end
    if (mem_stall) begin
      forever begin
        @(posedge clk); #1;
        idx++;
        drive_bus(v, idx);
        pipe_hold = 1'($urandom);
        #1;
        if (bus_if.bus_req) begin
          reqs++;
          chk({tag, " bus_addr"}, bus_if.bus_addr, {v.addr[31:2], 2'b00});
          chk({tag, " bus_we"}, 32'(bus_if.bus_we), 32'(v.we));
          chk({tag, " bus_wdata"}, bus_if.bus_wdata, v.wd);
        end
        if (!mem_stall) break;
        stalls++;
        if (idx > 40) begin
          chk({tag, " stall_budget"}, 32'(idx), 32'd40);
          break;
        end
      end
    end else begin
      @(posedge clk); #1;
      idx++;
      drive_bus(v, idx);
      #1;
    end
    pipe_hold = (v.hold > 0);
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    chk({tag, " req_cycles"}, 32'(reqs), 32'(v.exp_req));
    chk({tag, " done_req"}, 32'(bus_if.bus_req), 32'h0);
    chk({tag, " done_data"}, mem_data_o, v.exp_data);
    chk({tag, " done_err"}, 32'(dmem_err), 32'(v.exp_err));
    for (int unsigned h = 1; h <= v.hold; h++) begin
      @(posedge clk); #1;
      idx++;
      drive_bus(v, idx);
      pipe_hold = (h < v.hold);
      #1;
      chk({tag, " hold_stall"}, 32'(mem_stall), 32'h0);
      chk({tag, " hold_req"}, 32'(bus_if.bus_req), 32'h0);
      chk({tag, " hold_data"}, mem_data_o, v.exp_data);
      chk({tag, " hold_err"}, 32'(dmem_err), 32'(v.exp_err));
    end
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    pipe_hold = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1, 0, 32'h100, 32'h0,        1,  0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 2,  1);
    tbl[1] = mk(0, 1, 32'h204, 32'h12345678, 5,  0, 32'h0,        1, 32'hCAFEF00D, 0, 6,  5);
    tbl[2] = mk(1, 0, 32'h300, 32'h0,        19, 0, 32'h0BADBEEF, 3, 32'h0,        1, 17, 16);
    tbl[3] = mk(1, 0, 32'h102, 32'h0,        0,  0, 32'h0,        0, 32'h0,        1, 0,  0);
    tbl[4] = mk(1, 0, 32'h010, 32'h0,        1,  0, 32'hA5A5A5A5, 3, 32'hA5A5A5A5, 0, 2,  1);
    tbl[5] = mk(1, 0, 32'h010, 32'h0,        1,  0, 32'h11112222, 0, 32'h11112222, 0, 2,  1);
    tbl[6] = mk(1, 1, 32'h020, 32'h55AA55AA, 1,  0, 32'hFFFFFFFF, 0, 32'h11112222, 0, 2,  1);
    tbl[7] = mk(1, 0, 32'h040, 32'h0,        2,  1, 32'hDEADBEEF, 1, 32'h0,        1, 3,  2);
    tbl[8] = mk(0, 1, 32'h044, 32'h77777777, 3,  1, 32'h0,        0, 32'h0,        1, 4,  3);
    tbl[9] = mk(0, 0, 32'h048, 32'h0,        0,  0, 32'h0,        0, 32'h0,        0, 0,  0);

    rst = 1'b1;
    mem_addr = '0; mem_we = 1'b0; mem_re = 1'b0; mem_wd = '0; pipe_hold = 1'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", mem_data_o, 32'h0);
    chk("rst_err", 32'(dmem_err), 32'h0);
    chk("rst_req", 32'(bus_if.bus_req), 32'h0);
    chk("rst_we", 32'(bus_if.bus_we), 32'h0);
    chk("rst_addr", bus_if.bus_addr, 32'h0);
    chk("rst_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end
    model_data = tbl[9].exp_data;

    // Reset while BUSY abandons the access.
    mem_re = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; mem_wd = '0;
    @(posedge clk); #1;
    chk("midrst_req_before", 32'(bus_if.bus_req), 32'h1);
    rst = 1'b1; mem_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(bus_if.bus_req), 32'h0);
    chk("midrst_stall", 32'(mem_stall), 32'h0);
    chk("midrst_err", 32'(dmem_err), 32'h0);
    chk("midrst_data", mem_data_o, 32'h0);
    chk("midrst_addr", bus_if.bus_addr, 32'h0);
    model_data = 32'h0;

    for (int i = 0; i < 80; i++) begin
      vec_t        v;
      logic [31:0] a;
      int unsigned kind = $urandom_range(0, 9);
      a = $urandom;
      a[1:0] = 2'b00;
      v = mk(0, 0, a, $urandom, 0, 0, $urandom, $urandom_range(0, 3), 0, 0, 0, 0);
      if (kind != 0) begin
        case ($urandom_range(0, 2))
          0: begin v.re = 1'b1; v.we = 1'b0; end
          1: begin v.re = 1'b0; v.we = 1'b1; end
          default: begin v.re = 1'b1; v.we = 1'b1; end
        endcase
        if (kind == 1) v.addr[1:0] = 2'($urandom_range(1, 3));
        v.ack_on = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO) : $urandom_range(1, 3);
        v.err = ($urandom_range(0, 4) == 0);
      end
      v = model(v, model_data);
      run_txn(v, $sformatf("rnd%0d", i));
      model_data = v.exp_data;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-memory bus interface directly downstream of the MEM stage.
- Consumes the MEM stage's memory address, write-enable and write data, and performs a word access on a req/ack data bus.
- Stalls the pipeline while the access is outstanding.
- Returns registered load data to the MEM stage's memory read-data input and holds it across external pipeline holds.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles waiting for bus_ack before the access is aborted; legal range 2..2^CNT_W-1.
- CNT_W, 5, width of the timeout counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  input  32  access byte address from MEM stage.
- mem_we  input  1  store request from MEM stage.
- mem_re  input  1  load request (MemtoReg of the instruction in MEM).
- mem_wd  input  32  store data from MEM stage.
- pipe_hold  input  1  pipeline held by another hazard source; MEM inputs remain stable.
- mem_data_o  output  32  load data to MEM stage (drives its memory read-data input).
- mem_stall  output  1  freeze IF..MEM while the access is pending.
- dmem_err  output  1  access faulted (misaligned, bus_err or timeout).
- bus_req  output  1  bus request.
- bus_we  output  1  bus write strobe.
- bus_addr  output  32  bus word address.
- bus_wdata  output  32  bus write data.
- bus_ack  input  1  bus completion, single-cycle pulse.
- bus_err  input  1  bus error, qualified by bus_ack.
- bus_rdata  input  32  read data, valid when bus_ack=1.

Behaviour:
- **Reset:** rst=1 at a rising edge forces state IDLE and clears the timeout counter. It also clears mem_data_o, dmem_err, bus_req, bus_we, bus_addr and bus_wdata to 0. mem_stall=0 while in IDLE with no access pending.
- **Access decode:** acc = mem_we | mem_re. If both are set, the access is a store and mem_data_o is not updated. aligned = (mem_addr[1:0]==2'b00).
- **State IDLE:**
  - acc & aligned: mem_stall=1 combinationally. Register bus_addr={mem_addr[31:2],2'b00}, bus_wdata=mem_wd and bus_we=mem_we. Set bus_req=1, clear the counter and dmem_err, then go to BUSY.
  - acc & ~aligned: no bus request and no stall. dmem_err=1 for the following cycle (registered), then go to DONE. mem_data_o is unchanged.
  - ~acc: stay in IDLE; dmem_err cleared.
- **State BUSY:**
  - mem_stall=1.
  - bus_req, bus_we, bus_addr and bus_wdata are held stable until the cycle bus_ack is sampled high.
  - On bus_ack: drop bus_req next cycle. For a load, mem_data_o <= bus_err ? 0 : bus_rdata. dmem_err <= bus_err. Go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no ack: drop bus_req, dmem_err<=1, load mem_data_o<=0, go to DONE.
  - A bus_ack arriving after an abort is ignored.
- **State DONE:**
  - mem_stall=0, so the pipeline advances this cycle.
  - mem_data_o and dmem_err are held.
  - pipe_hold=1: stay in DONE with no reissue; the same instruction is still in MEM.
  - pipe_hold=0: go to IDLE. The next cycle's inputs are treated as a new instruction, even if identical.
- **Latency:** minimum store or load is 2 stall cycles (IDLE, BUSY with same-cycle ack). Load data is valid in DONE.
- **Back-to-back:** a new access is accepted in the IDLE cycle following DONE. bus_req therefore has at least one low cycle between accesses.
- **pipe_hold outside DONE:** ignored in IDLE and BUSY.
- **Reset mid-BUSY:** bus_req drops on the next edge and the access is abandoned. The bus must tolerate an abandoned request.
- **Width rules:** the counter saturates. Address bits [1:0] are never driven to the bus nonzero.

Test Plan:
- **Load, same-cycle ack:** mem_re=1, mem_addr=0x100. Bus acks in the first BUSY cycle with rdata=0xCAFEF00D. Required: bus_req high 1 cycle with bus_addr=0x100 and bus_we=0; mem_stall high 2 cycles; mem_data_o=0xCAFEF00D in DONE; dmem_err=0.
- **Store, delayed ack:** mem_we=1, addr=0x204, wd=0x12345678. Ack after 5 cycles. Required: bus_we=1, bus_wdata=0x12345678 stable throughout; mem_stall high 6 cycles; mem_data_o unchanged.
- **Timeout:** mem_re=1 with bus_ack held low, TIMEOUT=16. Required: bus_req drops after 16 BUSY cycles; dmem_err=1 and mem_data_o=0 in DONE. A late ack 3 cycles later has no effect.
- **Misaligned and bus_err:** mem_addr=0x102 with mem_re. Required: no bus_req, mem_stall=0, dmem_err=1 next cycle. Separately, an aligned load whose ack carries bus_err=1 gives dmem_err=1 and mem_data_o=0.
- **Hold in DONE and back-to-back:** assert pipe_hold for 3 cycles in DONE after a load of 0xA5A5A5A5. Required: state stays DONE, no second bus_req, mem_data_o stays 0xA5A5A5A5. Then release and present an identical load. Required: exactly one new bus_req, preceded by a low cycle.
- **Reset mid-BUSY:** assert rst in BUSY. Required: next cycle bus_req=0, mem_stall=0, dmem_err=0, mem_data_o=0, state IDLE.
